// File: rtl/axi_mem_responder.sv
// AXI4 memory responder: independent single-outstanding INCR write and read
// burst engines in front of a byte-enabled, word-addressed local RAM.
module axi_mem_responder #(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 64,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 512,
  parameter int unsigned C_MEM_DEPTH_LOG2   = 10
) (
  input  logic                              ap_clk,
  input  logic                              areset,
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                        s_axi_awlen,
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                              s_axi_wlast,
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                        s_axi_arlen,
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic                              s_axi_rlast,
  output logic                              err_wlast
);
  localparam int unsigned NB  = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned LSB = $clog2(NB);
  localparam int unsigned DL  = C_MEM_DEPTH_LOG2;
  localparam logic [DL-1:0] IDX_ONE = 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [0:(1<<DL)-1];

  w_state_e      w_state_q, w_state_d;
  logic [DL-1:0] w_idx_q, w_idx_d;
  logic [7:0]    w_len_q, w_len_d;
  logic [7:0]    w_cnt_q, w_cnt_d;
  logic          err_q, err_d;
  logic          w_fire;

  r_state_e      r_state_q, r_state_d;
  logic [DL-1:0] r_idx_q, r_idx_d;
  logic [7:0]    r_len_q, r_len_d;
  logic [7:0]    r_cnt_q, r_cnt_d;
  logic          rvalid_q, rvalid_d;
  logic          rlast_q, rlast_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic          rd_load;
  logic [DL-1:0] rd_addr;

  // Upper and sub-word address bits are intentionally ignored (RAM aliases).
  logic addr_unused;
  assign addr_unused = ^{s_axi_awaddr, s_axi_araddr};

  // Handshake-facing outputs are masked during reset so nothing is accepted.
  assign s_axi_awready = (w_state_q == W_IDLE) && !areset;
  assign s_axi_wready  = (w_state_q == W_DATA) && !areset;
  assign s_axi_bvalid  = (w_state_q == W_RESP) && !areset;
  assign s_axi_arready = (r_state_q == R_IDLE) && !areset;
  assign s_axi_rvalid  = rvalid_q && !areset;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rdata   = rdata_q;
  assign err_wlast     = err_q;
  assign w_fire        = s_axi_wvalid && s_axi_wready;

  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    err_d     = err_q;
    case (w_state_q)
      W_IDLE: if (s_axi_awvalid && s_axi_awready) begin
        w_idx_d   = s_axi_awaddr[LSB +: DL];
        w_len_d   = s_axi_awlen;
        w_cnt_d   = '0;
        w_state_d = W_DATA;
      end
      W_DATA: if (w_fire) begin
        w_idx_d = w_idx_q + IDX_ONE;
        w_cnt_d = w_cnt_q + 8'd1;
        if (s_axi_wlast != (w_cnt_q == w_len_q)) err_d = 1'b1;
        if (w_cnt_q == w_len_q) w_state_d = W_RESP;
      end
      W_RESP: if (s_axi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rd_load   = 1'b0;
    rd_addr   = r_idx_q;
    case (r_state_q)
      R_IDLE: if (s_axi_arvalid && s_axi_arready) begin
        rd_load   = 1'b1;
        rd_addr   = s_axi_araddr[LSB +: DL];
        r_idx_d   = s_axi_araddr[LSB +: DL] + IDX_ONE;
        r_len_d   = s_axi_arlen;
        r_cnt_d   = '0;
        rvalid_d  = 1'b1;
        rlast_d   = (s_axi_arlen == 8'd0);
        r_state_d = R_DATA;
      end
      R_DATA: if (s_axi_rvalid && s_axi_rready) begin
        if (rlast_q) begin
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          r_state_d = R_IDLE;
        end else begin
          rd_load = 1'b1;
          r_idx_d = r_idx_q + IDX_ONE;
          r_cnt_d = r_cnt_q + 8'd1;
          rlast_d = ((r_cnt_q + 8'd1) == r_len_q);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      err_q     <= 1'b0;
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      err_q     <= err_d;
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
    end
  end

  // RAM is left out of reset; the read port sees pre-write contents (read-first).
  always_ff @(posedge ap_clk) begin
    if (w_fire) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (s_axi_wstrb[b]) mem[w_idx_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (areset)       rdata_q <= '0;
    else if (rd_load) rdata_q <= mem[rd_addr];
  end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: a shadow RAM predicts every R beat,
// and B responses are counted against the bursts issued.
module tb_axi_mem_responder;
  localparam int unsigned AW    = 64;
  localparam int unsigned DW    = 512;
  localparam int unsigned NB    = DW / 8;
  localparam int unsigned DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          areset = 1'b1;
  logic          awvalid = 1'b0, awready;
  logic [AW-1:0] awaddr = '0;
  logic [7:0]    awlen = '0;
  logic          wvalid = 1'b0, wready;
  logic [DW-1:0] wdata = '0;
  logic [NB-1:0] wstrb = '0;
  logic          wlast = 1'b0;
  logic          bvalid, bready = 1'b0;
  logic          arvalid = 1'b0, arready;
  logic [AW-1:0] araddr = '0;
  logic [7:0]    arlen = '0;
  logic          rvalid, rready = 1'b0, rlast;
  logic [DW-1:0] rdata;
  logic          err_wlast;

  axi_mem_responder #(
    .C_S_AXI_ADDR_WIDTH(AW),
    .C_S_AXI_DATA_WIDTH(DW),
    .C_MEM_DEPTH_LOG2(10)
  ) dut (
    .ap_clk(clk), .areset(areset),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wlast(wlast), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rlast(rlast),
    .err_wlast(err_wlast)
  );

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  int unsigned   b_seen = 0;
  int unsigned   b_exp  = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW:0]   sb [$];
  logic [DW-1:0] wq_d [$];
  logic [NB-1:0] wq_s [$];
  logic [3:0]    pat = 4'b1001;

  task automatic check(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned idx_of(input logic [AW-1:0] a);
    return 32'((a / NB) % DEPTH);
  endfunction

  always @(negedge clk) if (bvalid && bready) b_seen++;

  logic [DW:0] r_prev;
  logic        r_stalled = 1'b0;
  always @(negedge clk) begin
    logic [DW:0] e;
    if (areset) r_stalled = 1'b0;
    else begin
      if (r_stalled) begin
        check("r_hold", rvalid, 1);
        check("r_stable", {rlast, rdata}, r_prev);
      end
      if (rvalid && rready) begin
        check("r_sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("r_beat", {rlast, rdata}, e);
        end
      end
      r_stalled = rvalid && !rready;
      r_prev    = {rlast, rdata};
    end
  end

  task automatic do_write(input logic [AW-1:0] addr, input int unsigned len,
                          input int unsigned last_at, input int unsigned bstall);
    int unsigned idx, k;
    idx = idx_of(addr);
    awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!awready && k < 50) begin k++; @(negedge clk); end
    check("aw_ready", awready, 1);
    @(posedge clk); #1 awvalid = 1'b0;
    for (int unsigned i = 0; i <= len; i++) begin
      wvalid = 1'b1; wdata = wq_d[i]; wstrb = wq_s[i]; wlast = (i == last_at);
      k = 0;
      @(negedge clk);
      while (!wready && k < 50) begin k++; @(negedge clk); end
      check("w_ready", wready, 1);
      for (int unsigned b = 0; b < NB; b++)
        if (wq_s[i][b]) model[idx][8*b +: 8] = wq_d[i][8*b +: 8];
      idx = (idx + 1) % DEPTH;
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0; bready = (bstall == 0);
    @(negedge clk);
    check("b_valid", bvalid, 1);
    for (int unsigned s = 0; s < bstall; s++) begin
      check("aw_blocked", awready, 0);
      @(posedge clk); #1;
      if (s + 1 == bstall) bready = 1'b1;
      @(negedge clk);
      check("b_hold", bvalid, 1);
    end
    @(posedge clk); #1 bready = 1'b0; b_exp++;
    @(negedge clk);
    check("b_drop", bvalid, 0);
    check("aw_turn", awready, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int unsigned len, input int unsigned mode);
    int unsigned idx, k, n;
    logic done;
    idx = idx_of(addr);
    for (int unsigned i = 0; i <= len; i++)
      sb.push_back({i == len, model[(idx + i) % DEPTH]});
    araddr = addr; arlen = 8'(len); arvalid = 1'b1; rready = 1'b1;
    k = 0;
    @(negedge clk);
    while (!arready && k < 50) begin k++; @(negedge clk); end
    check("ar_ready", arready, 1);
    @(posedge clk); #1 arvalid = 1'b0;
    @(negedge clk);
    check("r_lat", rvalid, 1);
    n = 0; done = 1'b0;
    while (!done && n < 2000) begin
      if (mode == 0) check("r_nobubble", rvalid, 1);
      done = rvalid && rready && rlast;
      @(posedge clk); #1; n++;
      rready = (mode == 0) || pat[n % 4];
      if (!done) @(negedge clk);
    end
    check("r_done", done, 1);
    @(negedge clk);
    check("r_end", rvalid, 0);
    check("ar_turn", arready, 1);
    @(posedge clk); #1 rready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 areset = 1'b0;
    @(negedge clk);
    check("rst_awready", awready, 1);
    check("rst_arready", arready, 1);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_rdata", rdata, 0);
    check("rst_err", err_wlast, 0);
    @(posedge clk); #1;

    // single beat
    wq_d.delete(); wq_s.delete();
    wq_d.push_back({NB{8'hA5}}); wq_s.push_back('1);
    do_write(64'h40, 0, 0, 0);
    do_read(64'h40, 0, 0);
    do_read(64'h10047, 0, 0);

    // 256-beat burst
    wq_d.delete(); wq_s.delete();
    for (int unsigned i = 0; i < 256; i++) begin wq_d.push_back(DW'(i)); wq_s.push_back('1); end
    do_write(64'h0, 255, 255, 0);
    do_read(64'h0, 255, 0);

    // strobes at the top index
    wq_d.delete(); wq_s.delete();
    wq_d.push_back('1); wq_s.push_back('1);
    do_write(64'hFFC0, 0, 0, 0);
    wq_d.delete(); wq_s.delete();
    wq_d.push_back('0); wq_s.push_back(NB'(1));
    do_write(64'hFFC0, 0, 0, 0);
    do_read(64'hFFC0, 0, 0);

    // index wrap
    wq_d.delete(); wq_s.delete();
    wq_d.push_back(DW'(32'hAAAA_0001)); wq_s.push_back('1);
    wq_d.push_back(DW'(32'hBBBB_0002)); wq_s.push_back('1);
    do_write(64'hFFC0, 1, 1, 0);
    do_read(64'hFFC0, 1, 0);
    do_read(64'h0, 0, 0);

    // backpressure on B and R
    wq_d.delete(); wq_s.delete();
    for (int unsigned i = 0; i < 3; i++) begin wq_d.push_back({16{32'hC0DE_0000 + i}}); wq_s.push_back('1); end
    do_write(64'h1000, 2, 2, 5);
    do_read(64'h0, 5, 1);
    do_read(64'h1000, 2, 1);

    // wlast mismatch
    check("err_before", err_wlast, 0);
    wq_d.delete(); wq_s.delete();
    for (int unsigned i = 0; i < 4; i++) begin wq_d.push_back({16{32'hE000_0000 + i}}); wq_s.push_back('1); end
    do_write(64'h2000, 3, 1, 0);
    check("err_set", err_wlast, 1);
    do_read(64'h2000, 3, 0);
    do_write(64'h3000, 3, 3, 0);
    check("err_sticky", err_wlast, 1);

    // reset in the middle of a write burst
    wq_d.delete(); wq_s.delete();
    for (int unsigned i = 0; i < 8; i++) begin wq_d.push_back({16{32'h7000_0000 + i}}); wq_s.push_back('1); end
    awaddr = 64'h4000; awlen = 8'd7; awvalid = 1'b1;
    @(negedge clk);
    check("rb_aw", awready, 1);
    @(posedge clk); #1 awvalid = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      wvalid = 1'b1; wdata = wq_d[i]; wstrb = '1; wlast = 1'b0;
      @(negedge clk);
      check("rb_wready", wready, 1);
      model[(idx_of(64'h4000) + i) % DEPTH] = wq_d[i];
      @(posedge clk); #1;
    end
    wdata = wq_d[3]; areset = 1'b1;
    @(posedge clk); #1 wvalid = 1'b0;
    @(negedge clk);
    check("rb_bvalid", bvalid, 0);
    check("rb_rvalid", rvalid, 0);
    check("rb_awready", awready, 0);
    check("rb_arready", arready, 0);
    check("rb_err_clr", err_wlast, 0);
    @(posedge clk); #1 areset = 1'b0;
    @(negedge clk);
    check("rb_aw_up", awready, 1);
    check("rb_ar_up", arready, 1);
    repeat (4) @(negedge clk);
    check("rb_no_b", b_seen, b_exp);
    @(posedge clk); #1;
    wq_d.delete(); wq_s.delete();
    for (int unsigned i = 0; i < 4; i++) begin wq_d.push_back({16{32'h5000_0000 + i}}); wq_s.push_back('1); end
    do_write(64'h5000, 3, 3, 0);
    do_read(64'h5000, 3, 0);
    check("rb_err_after", err_wlast, 0);

    check("b_count", b_seen, b_exp);
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
